bin_to_bcd_serial: RTL

Parametrised, handshaked serial binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one input bit per clock. It is the general successor to the game's fixed 6-bit score/timer converter and feeds the seven-segment display driver. It adds:
- configurable input width and digit count
- start/ready/valid handshake
- leading-zero blanking mask
- overflow detection

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_dabble_digit.sv | 15 +
 rtl/bin_to_bcd_serial.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial binary-to-BCD converter.
//   state_e      : converter FSM states (IDLE, SHIFT)
//   BCD_DIGIT_W  : width of one BCD digit
//   cnt_w()      : width of the bit counter for a given binary input width
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int BCD_DIGIT_W = 4;

  // The counter must hold BIN_W itself, not just BIN_W-1.
  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// Combinational add-3 correction for one BCD digit of the double-dabble
// algorithm: a digit of 5 or more gets +3 so that the following left shift
// carries correctly into the next decimal digit.
//   digit_i : current 4-bit digit
//   digit_o : corrected digit (no carry out; 5..9 map to 8..12)
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start accepted while idle samples bin_i; BIN_W cycles later valid_o
// pulses with the registered result.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   start_i    : conversion request, accepted only while ready_o=1
//   bin_i      : binary value, sampled on the accepting edge
//   ready_o    : converter idle
//   valid_o    : one-cycle pulse, outputs updated this cycle
//   bcd_o      : result, digit i at [4i+3:4i], digit 0 = ones
//   blank_o    : bit i set when digit i is a suppressible leading zero
//   overflow_o : input exceeded 10^DIGITS-1 (bcd_o holds bin mod 10^DIGITS)
module bin_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [BIN_W-1:0]              bin_i,
  output logic                          ready_o,
  output logic                          valid_o,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic [DIGITS-1:0]             blank_o,
  output logic                          overflow_o
);

  localparam int CNT_W = cnt_w(BIN_W);
  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} ^ DIGITS'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               oflow_q, oflow_d;
  logic               valid_q, valid_d;

  logic [ACC_W-1:0]   acc_corr;
  logic [ACC_W-1:0]   acc_shift;
  logic               ovf_next;

  // Leading-zero mask: digit i blanks when it and every digit above it is
  // zero. Digit 0 never blanks so a zero result still shows one "0".
  function automatic logic [DIGITS-1:0] blank_of(input logic [ACC_W-1:0] d);
    logic [DIGITS-1:0] b;
    logic              any_nz;
    b      = '0;
    any_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      any_nz = any_nz | (|d[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
      b[i]   = ~any_nz;
    end
    return b;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit_i (acc_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit_o (acc_corr[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // Corrected digits shift left as one word with the binary MSB entering
  // digit 0; a set MSB of the corrected top digit is a decimal carry that
  // falls off the end, i.e. the value no longer fits in DIGITS digits.
  assign acc_shift = {acc_corr[ACC_W-2:0], sr_q[BIN_W-1]};
  assign ovf_next  = ovf_q | acc_corr[ACC_W-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    oflow_d = oflow_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sr_d    = bin_i;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        sr_d  = {sr_q[BIN_W-2:0], 1'b0};
        ovf_d = ovf_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = acc_shift;
          blank_d = blank_of(acc_shift);
          oflow_d = ovf_next;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      oflow_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      oflow_q <= oflow_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign valid_o    = valid_q;
  assign bcd_o      = bcd_q;
  assign blank_o    = blank_q;
  assign overflow_o = oflow_q;

endmodule
